// File: rtl/i2c_slave_regs.sv
// I2C target with an auto-incrementing 8-bit register port.
// Optional I2C_SLAVE_FILTER_EN adds a 3-sample majority glitch filter on SCL/SDA.
module i2c_slave_regs #(
  parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i2c_sclk,
  inout  wire        i2c_sdat,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK
  } state_t;

  state_t      state;
  logic [1:0]  scl_sync, sda_sync;
  logic        scl_s, sda_s, scl_d, sda_d;
  logic        scl_rise, scl_fall, start_det, stop_det;
  logic [7:0]  shifter;
  logic [7:0]  rx_byte;
  logic [3:0]  bit_cnt;
  logic        rw, sda_oe, ack_rise;

  assign i2c_sdat = sda_oe ? 1'b0 : 1'bz;

  // Synchronizers reset to 1 so an idle bus never looks like an edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], i2c_sclk};
      sda_sync <= {sda_sync[0], i2c_sdat};
    end
  end

`ifdef I2C_SLAVE_FILTER_EN
  logic [2:0] scl_hist, sda_hist;

  always_ff @(posedge clk) begin
    if (!reset) begin
      scl_hist <= 3'b111;
      sda_hist <= 3'b111;
    end else begin
      scl_hist <= {scl_hist[1:0], scl_sync[1]};
      sda_hist <= {sda_hist[1:0], sda_sync[1]};
    end
  end

  assign scl_s = (scl_hist[0] & scl_hist[1]) | (scl_hist[0] & scl_hist[2]) |
                 (scl_hist[1] & scl_hist[2]);
  assign sda_s = (sda_hist[0] & sda_hist[1]) | (sda_hist[0] & sda_hist[2]) |
                 (sda_hist[1] & sda_hist[2]);
`else
  assign scl_s = scl_sync[1];
  assign sda_s = sda_sync[1];
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_s;
      sda_d <= sda_s;
    end
  end

  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
  assign rx_byte   = {shifter[6:0], sda_s};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      reg_addr  <= 8'h00;
      reg_wdata <= 8'h00;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      busy      <= 1'b0;
      shifter   <= 8'h00;
      bit_cnt   <= 4'd0;
      rw        <= 1'b0;
      sda_oe    <= 1'b0;
      ack_rise  <= 1'b0;
    end else begin
      reg_we <= 1'b0;
      reg_re <= 1'b0;
      if (reg_we) reg_addr <= reg_addr + 8'd1;

      if (start_det) begin
        state    <= ADDR;
        bit_cnt  <= 4'd0;
        sda_oe   <= 1'b0;
        ack_rise <= 1'b0;
      end else if (stop_det) begin
        state    <= IDLE;
        busy     <= 1'b0;
        bit_cnt  <= 4'd0;
        sda_oe   <= 1'b0;
        ack_rise <= 1'b0;
      end else begin
        case (state)
          ADDR, PTR, WDATA: begin
            if (scl_rise) begin
              shifter <= rx_byte;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                bit_cnt  <= 4'd0;
                ack_rise <= 1'b0;
                case (state)
                  ADDR: begin
                    // General call (address 0) is never acknowledged.
                    if (rx_byte[7:1] == SLAVE_ADDR && rx_byte[7:1] != 7'd0) begin
                      state <= ADDR_ACK;
                      busy  <= 1'b1;
                      rw    <= rx_byte[0];
                    end else begin
                      state <= IDLE;
                      busy  <= 1'b0;
                    end
                  end
                  PTR: begin
                    reg_addr <= rx_byte;
                    state    <= PTR_ACK;
                  end
                  default: begin
                    reg_wdata <= rx_byte;
                    reg_we    <= 1'b1;
                    state     <= WDATA_ACK;
                  end
                endcase
              end
            end
          end
          ADDR_ACK, PTR_ACK, WDATA_ACK: begin
            // First fall starts the ACK pulse, the fall after the 9th rise ends it.
            if (scl_fall) begin
              if (!ack_rise) begin
                sda_oe <= 1'b1;
              end else begin
                sda_oe   <= 1'b0;
                ack_rise <= 1'b0;
                if (state == ADDR_ACK && rw) begin
                  state  <= RDATA;
                  reg_re <= 1'b1;
                end else if (state == ADDR_ACK) begin
                  state <= PTR;
                end else begin
                  state <= WDATA;
                end
              end
            end else if (scl_rise && sda_oe) begin
              ack_rise <= 1'b1;
            end
          end
          RDATA: begin
            // reg_rdata is captured during the cycle reg_re is high.
            if (reg_re) begin
              shifter <= reg_rdata;
              sda_oe  <= ~reg_rdata[7];
              bit_cnt <= 4'd0;
            end else if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe   <= 1'b0;
                ack_rise <= 1'b0;
                state    <= RACK;
              end else begin
                shifter <= {shifter[6:0], 1'b0};
                sda_oe  <= ~shifter[6];
              end
            end
          end
          RACK: begin
            if (scl_rise) begin
              if (!sda_s) begin
                ack_rise <= 1'b1;
                reg_addr <= reg_addr + 8'd1;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else if (scl_fall && ack_rise) begin
              ack_rise <= 1'b0;
              reg_re   <= 1'b1;
              state    <= RDATA;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed testbench for i2c_slave_regs: write, read, mismatch, wrap, abort/reset.
module tb_i2c_slave_regs;

  localparam time Q = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  wire        sda_bus;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_we, reg_re, busy;

  int checks = 0;
  int errors = 0;
  int we_n = 0;
  int re_n = 0;
  logic [7:0] we_a [16];
  logic [7:0] we_d [16];

  pullup (sda_bus);
  assign sda_bus   = m_low ? 1'b0 : 1'bz;
  assign reg_rdata = reg_addr ^ 8'hFF;

  always #5 clk = ~clk;

  i2c_slave_regs #(.SLAVE_ADDR(7'h42)) dut (
    .clk       (clk),
    .reset     (reset),
    .i2c_sclk  (scl),
    .i2c_sdat  (sda_bus),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .busy      (busy)
  );

  // Strobe log, sampled on the falling clock edge.
  always @(negedge clk) begin
    if (reg_we && we_n < 16) begin
      we_a[we_n] = reg_addr;
      we_d[we_n] = reg_wdata;
      we_n++;
    end
    if (reg_re) re_n++;
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic i2c_start();
    if (scl == 1'b0) begin
      m_low = 1'b0; #(Q);
      scl = 1'b1;   #(Q);
    end
    m_low = 1'b1; #(Q);
    scl = 1'b0;   #(Q);
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; #(Q);
    scl = 1'b1;   #(Q);
    m_low = 1'b0; #(2*Q);
  endtask

  task automatic send_bit(input logic b);
    m_low = ~b; #(Q);
    scl = 1'b1; #(2*Q);
    scl = 1'b0; #(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    m_low = 1'b0; #(Q);
    scl = 1'b1;   #(Q);
    ack = sda_bus;
    #(Q);
    scl = 1'b0;   #(Q);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    for (int i = 7; i >= 0; i--) begin
      m_low = 1'b0; #(Q);
      scl = 1'b1;   #(Q);
      d[i] = sda_bus;
      #(Q);
      scl = 1'b0;   #(Q);
    end
    m_low = ~nack; #(Q);
    scl = 1'b1;    #(2*Q);
    scl = 1'b0;
    m_low = 1'b0;  #(Q);
  endtask

  logic       ack;
  logic [7:0] rd;
  int         re_base, we_base;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_addr", reg_addr, 8'h00);
    check_output("rst_we", reg_we, 1'b0);
    check_output("rst_re", reg_re, 1'b0);
    check_output("rst_busy", busy, 1'b0);
    check_output("rst_sda", sda_bus, 1'b1);
    @(negedge clk) reset = 1'b1;
    repeat (4) @(posedge clk);

    $display("[TB] write: ptr 0x10, data 0xAA 0x55");
    i2c_start();
    write_byte(8'h84, ack); check_output("wr_addr_ack", ack, 1'b0);
    check_output("wr_busy", busy, 1'b1);
    write_byte(8'h10, ack); check_output("wr_ptr_ack", ack, 1'b0);
    write_byte(8'hAA, ack); check_output("wr_d0_ack", ack, 1'b0);
    write_byte(8'h55, ack); check_output("wr_d1_ack", ack, 1'b0);
    i2c_stop();
    check_output("wr_we_count", we_n, 2);
    check_output("wr_we0_addr", we_a[0], 8'h10);
    check_output("wr_we0_data", we_d[0], 8'hAA);
    check_output("wr_we1_addr", we_a[1], 8'h11);
    check_output("wr_we1_data", we_d[1], 8'h55);
    check_output("wr_final_addr", reg_addr, 8'h12);
    check_output("wr_busy_after_stop", busy, 1'b0);

    $display("[TB] read: ptr 0x20, repeated start, three bytes");
    re_base = re_n;
    i2c_start();
    write_byte(8'h84, ack); check_output("rd_waddr_ack", ack, 1'b0);
    write_byte(8'h20, ack); check_output("rd_ptr_ack", ack, 1'b0);
    i2c_start();
    write_byte(8'h85, ack); check_output("rd_raddr_ack", ack, 1'b0);
    read_byte(rd, 1'b0); check_output("rd_byte0", rd, 8'hDF);
    read_byte(rd, 1'b0); check_output("rd_byte1", rd, 8'hDE);
    read_byte(rd, 1'b1); check_output("rd_byte2", rd, 8'hDD);
    check_output("rd_busy_after_nack", busy, 1'b0);
    i2c_stop();
    check_output("rd_re_count", re_n - re_base, 3);
    check_output("rd_final_addr", reg_addr, 8'h22);
    check_output("rd_no_we", we_n, 2);

    $display("[TB] address mismatch 0x43");
    re_base = re_n;
    i2c_start();
    write_byte(8'h86, ack); check_output("mm_nack", ack, 1'b1);
    check_output("mm_busy", busy, 1'b0);
    i2c_stop();
    check_output("mm_no_we", we_n, 2);
    check_output("mm_no_re", re_n - re_base, 0);

    $display("[TB] pointer wrap at 0xFF");
    i2c_start();
    write_byte(8'h84, ack); check_output("wrap_addr_ack", ack, 1'b0);
    write_byte(8'hFF, ack);
    write_byte(8'h01, ack);
    write_byte(8'h02, ack); check_output("wrap_d1_ack", ack, 1'b0);
    i2c_stop();
    check_output("wrap_we_count", we_n, 4);
    check_output("wrap_we0_addr", we_a[2], 8'hFF);
    check_output("wrap_we0_data", we_d[2], 8'h01);
    check_output("wrap_we1_addr", we_a[3], 8'h00);
    check_output("wrap_we1_data", we_d[3], 8'h02);
    check_output("wrap_final_addr", reg_addr, 8'h01);

    $display("[TB] abort: stop after four data bits");
    i2c_start();
    write_byte(8'h84, ack);
    write_byte(8'h30, ack); check_output("ab_ptr_ack", ack, 1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    i2c_stop();
    check_output("ab_no_we", we_n, 4);
    check_output("ab_busy", busy, 1'b0);
    check_output("ab_addr", reg_addr, 8'h30);

    $display("[TB] reset during address ACK");
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(((8'h84 >> i) & 8'h01) != 0);
    m_low = 1'b0;
    check_output("rs_ack_driven", sda_bus, 1'b0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
    check_output("rs_sda_released", sda_bus, 1'b1);
    check_output("rs_busy", busy, 1'b0);
    check_output("rs_addr", reg_addr, 8'h00);
    check_output("rs_we", reg_we, 1'b0);
    check_output("rs_re", reg_re, 1'b0);
    @(negedge clk) reset = 1'b1;
    #(Q);
    scl = 1'b1; #(2*Q);
    scl = 1'b0; #(Q);
    i2c_stop();

`ifdef I2C_SLAVE_FILTER_EN
    $display("[TB] filter: 1-clk SDA glitch while SCL high");
    we_base = we_n;
    i2c_start();
    write_byte(8'h84, ack);
    write_byte(8'h40, ack);
    m_low = 1'b1; #(Q);
    scl = 1'b1;   #(Q);
    @(negedge clk) m_low = 1'b0;
    @(negedge clk) m_low = 1'b1;
    #(Q);
    scl = 1'b0;   #(Q);
    check_output("flt_busy", busy, 1'b1);
    for (int i = 6; i >= 0; i--) send_bit(((8'h3C >> i) & 8'h01) != 0);
    m_low = 1'b0; #(Q); scl = 1'b1; #(2*Q); scl = 1'b0; #(Q);
    i2c_stop();
    check_output("flt_we_count", we_n - we_base, 1);
    check_output("flt_we_data", we_d[we_base], 8'h3C);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
